// File: rtl/mem_byte_sequencer.sv
// Splits a 1..4 byte little-endian load/store into single-byte accesses on a
// handshaked byte memory bus and returns a zero-extended word response.
module mem_byte_sequencer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [7:0]        mem_read_value,
    output logic              mem_write,
    output logic [7:0]        mem_write_value
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    function automatic logic [7:0] get_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (lane)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w = word;
        endcase
        return w;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       acc_q, acc_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [7:0]        mem_write_value_q, mem_write_value_d;

    // Next-state logic for the transaction FSM and captured request
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        size_d  = size_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d  = req_size;
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    acc_d   = 32'd0;
                    k_d     = 2'd0;
                    state_d = S_XFER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                // a strobe is always up in XFER, so mem_ready alone completes the byte
                if (mem_ready) begin
                    if (!write_q) begin
                        acc_d = put_lane(acc_q, k_q, mem_read_value);
                    end else begin
                        acc_d = acc_q;
                    end
                    if (k_q == size_q) begin
                        state_d = S_RESP;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else begin
                    state_d = S_XFER;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they leave the chip from flops
    always_comb begin
        req_ready_d       = (state_d == S_IDLE);
        rsp_valid_d       = (state_d == S_RESP);
        rsp_rdata_d       = 32'd0;
        mem_address_d     = '0;
        mem_read_d        = 1'b0;
        mem_write_d       = 1'b0;
        mem_write_value_d = 8'd0;
        if (state_d == S_XFER) begin
            mem_address_d     = addr_d + ADDR_W'(k_d);
            mem_read_d        = ~write_d;
            mem_write_d       = write_d;
            mem_write_value_d = get_lane(wdata_d, k_d);
        end else if (state_d == S_RESP) begin
            rsp_rdata_d = write_d ? 32'd0 : acc_d;
        end else begin
            rsp_rdata_d = 32'd0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            k_q               <= 2'd0;
            size_q            <= 2'd0;
            write_q           <= 1'b0;
            addr_q            <= '0;
            wdata_q           <= 32'd0;
            acc_q             <= 32'd0;
            req_ready_q       <= 1'b1;
            rsp_valid_q       <= 1'b0;
            rsp_rdata_q       <= 32'd0;
            mem_address_q     <= '0;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_write_value_q <= 8'd0;
        end else begin
            state_q           <= state_d;
            k_q               <= k_d;
            size_q            <= size_d;
            write_q           <= write_d;
            addr_q            <= addr_d;
            wdata_q           <= wdata_d;
            acc_q             <= acc_d;
            req_ready_q       <= req_ready_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_rdata_q       <= rsp_rdata_d;
            mem_address_q     <= mem_address_d;
            mem_read_q        <= mem_read_d;
            mem_write_q       <= mem_write_d;
            mem_write_value_q <= mem_write_value_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign mem_address     = mem_address_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_write_value = mem_write_value_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed plus randomized bench for mem_byte_sequencer; the bench plays the
// byte memory and predicts every output cycle from a flat byte-array model.
module tb_mem_byte_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        mem_ready;
    logic [15:0] mem_address;
    logic        mem_read;
    logic [7:0]  mem_read_value;
    logic        mem_write;
    logic [7:0]  mem_write_value;

    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_byte_sequencer #(.ADDR_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_ready(mem_ready), .mem_address(mem_address), .mem_read(mem_read),
        .mem_read_value(mem_read_value), .mem_write(mem_write),
        .mem_write_value(mem_write_value)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
        chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
        chk({tag, "_mem_address"}, {16'd0, mem_address}, 32'd0);
        chk({tag, "_mem_wval"}, {24'd0, mem_write_value}, 32'd0);
    endtask

    // Runs one transaction; entered and left at a falling edge with DUT idle.
    task automatic run_txn(input bit wr, input logic [1:0] sz, input logic [15:0] a,
                           input logic [31:0] wd, input int first_waits, input bit rnd_waits,
                           input int rsp_waits, input bit noise);
        logic [31:0] exp_rdata;
        logic [15:0] ea;
        int          waits;
        exp_rdata = 32'd0;
        if (!wr) begin
            for (int i = 0; i <= int'(sz); i++) begin
                ea = a + 16'(i);
                exp_rdata = exp_rdata | (32'(mem[ea]) << (8 * i));
            end
        end
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
        mem_ready = 1'b0; rsp_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i <= int'(sz); i++) begin
            ea = a + 16'(i);
            waits = (i == 0) ? first_waits : 0;
            if (rnd_waits) waits = waits + int'($urandom_range(0, 2));
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                chk("xfer_addr", {16'd0, mem_address}, {16'd0, ea});
                chk("xfer_read", {31'd0, mem_read}, {31'd0, ~wr});
                chk("xfer_write", {31'd0, mem_write}, {31'd0, wr});
                chk("xfer_wval", {24'd0, mem_write_value}, {24'd0, wd[8*i +: 8]});
                chk("xfer_req_ready", {31'd0, req_ready}, 32'd0);
                chk("xfer_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                req_valid = noise ? 1'($urandom) : 1'b0;
                req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = $urandom;
                req_size  = 2'($urandom);
                rsp_ready = noise ? 1'($urandom) : 1'b0;
                mem_ready = (w == waits);
                mem_read_value = (w == waits && !wr) ? mem[ea] : 8'($urandom);
                if (w == waits && wr) mem[ea] = wd[8*i +: 8];
                @(posedge clk);
            end
        end
        for (int r = 0; r <= rsp_waits; r++) begin
            @(negedge clk);
            chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("resp_rdata", rsp_rdata, exp_rdata);
            chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
            check_quiet("resp");
            req_valid = noise;
            rsp_ready = (r == rsp_waits);
            mem_ready = 1'($urandom);
            mem_read_value = 8'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        chk("back_req_ready", {31'd0, req_ready}, 32'd1);
        chk("back_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_quiet("back");
        req_valid = 1'b0; rsp_ready = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_addr = 16'd0; req_wdata = 32'd0; rsp_ready = 1'b0; mem_ready = 1'b0;
        mem_read_value = 8'd0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_quiet("rst");
        reset = 1'b0;

        // 4-byte load from 0x0010
        mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
        run_txn(1'b0, 2'd3, 16'h0010, 32'h0, 0, 1'b0, 0, 1'b0);

        // Wrapping 2-byte store at 0xFFFF
        run_txn(1'b1, 2'd1, 16'hFFFF, 32'h0000BEEF, 0, 1'b0, 0, 1'b0);

        // 1-byte load with three wait cycles
        run_txn(1'b0, 2'd0, 16'h1234, 32'h0, 3, 1'b0, 0, 1'b0);

        // Response backpressure for two cycles with req_valid held high
        run_txn(1'b0, 2'd2, 16'h0100, 32'hA5A5A5A5, 0, 1'b0, 2, 1'b1);

        // Reset during the second byte of a 4-byte load
        chk("abort_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_addr = 16'h0200;
        req_wdata = 32'd0; mem_ready = 1'b1; mem_read_value = mem[16'h0200];
        @(posedge clk);
        @(negedge clk);
        chk("abort_b0_addr", {16'd0, mem_address}, 32'h0200);
        req_valid = 1'b0; mem_read_value = mem[16'h0200];
        @(posedge clk);
        @(negedge clk);
        chk("abort_b1_addr", {16'd0, mem_address}, 32'h0201);
        reset = 1'b1; req_valid = 1'b1; mem_ready = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_quiet("abort");
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; mem_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            mem_ready = 1'($urandom); rsp_ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("abort_after_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("abort_after_rd", {31'd0, mem_read}, 32'd0);
        end
        mem_ready = 1'b0; rsp_ready = 1'b0;

        // Randomized transactions, some near the top of the address space
        for (int t = 0; t < 40; t++) begin
            logic [15:0] a;
            a = (t % 4 == 0) ? (16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
            run_txn(1'($urandom), 2'($urandom), a, $urandom, int'($urandom_range(0, 1)),
                    1'b1, int'($urandom_range(0, 2)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
